// File: rtl/camera_scan_sequencer_if.sv
// Control-panel / camera-enable bundle for the camera scan sequencer.
// The panel side is the master; the sequencer is the slave.
interface camera_scan_sequencer_if #(
  parameter int unsigned NUM_CAMS     = 3,
  parameter int unsigned BITS_PER_CAM = 3,
  parameter int unsigned DWELL_W      = 8
);
  localparam int unsigned CAM_IDX_W = $clog2(NUM_CAMS);
  localparam int unsigned MASK_W    = NUM_CAMS * BITS_PER_CAM;

  logic                 enable;
  logic                 dir;
  logic [DWELL_W-1:0]   dwell;
  logic                 mode;
  logic [CAM_IDX_W-1:0] manual_sel;
  logic                 sel_valid;
  logic [NUM_CAMS-1:0]  alarm_in;
  logic [MASK_W-1:0]    mask;
  logic [CAM_IDX_W-1:0] active_idx;
  logic                 step;
  logic                 alarm_active;
  logic                 sel_err;

  modport master (
    output enable, dir, dwell, mode, manual_sel, sel_valid, alarm_in,
    input  mask, active_idx, step, alarm_active, sel_err
  );

  modport slave (
    input  enable, dir, dwell, mode, manual_sel, sel_valid, alarm_in,
    output mask, active_idx, step, alarm_active, sel_err
  );
endinterface

// File: rtl/camera_scan_sequencer.sv
// Camera scan sequencer: timed auto-scan, manual select and alarm override
// driving a one-group-hot activation mask.
module camera_scan_sequencer #(
  parameter int unsigned NUM_CAMS     = 3,
  parameter int unsigned BITS_PER_CAM = 3,
  parameter int unsigned DWELL_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  camera_scan_sequencer_if.slave   bus
);
  localparam int unsigned CAM_IDX_W = $clog2(NUM_CAMS);
  localparam int unsigned MASK_W    = NUM_CAMS * BITS_PER_CAM;

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_ALARM  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CAM_IDX_W-1:0] idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [MASK_W-1:0]    mask_q, mask_d;
  logic                 step_q, step_d;
  logic                 alarm_q, alarm_d;
  logic                 err_q, err_d;

  logic [CAM_IDX_W-1:0] alarm_idx;
  logic [CAM_IDX_W-1:0] adv_idx;
  logic [DWELL_W-1:0]   dwell_eff;
  logic                 expire;
  logic                 sel_in_range;

  // Lowest-numbered alarming camera wins.
  always_comb begin
    alarm_idx = '0;
    for (int i = int'(NUM_CAMS) - 1; i >= 0; i--) begin
      if (bus.alarm_in[i]) alarm_idx = CAM_IDX_W'(i);
    end
  end

  // A dwell of 0 behaves as 1; >= keeps a lowered dwell from stalling the scan.
  always_comb begin
    dwell_eff    = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    expire       = (cnt_q >= (dwell_eff - DWELL_W'(1)));
    sel_in_range = (32'(bus.manual_sel) < NUM_CAMS);
    if (bus.dir) begin
      adv_idx = (idx_q == '0) ? CAM_IDX_W'(NUM_CAMS - 1) : idx_q - CAM_IDX_W'(1);
    end else begin
      adv_idx = (idx_q == CAM_IDX_W'(NUM_CAMS - 1)) ? '0 : idx_q + CAM_IDX_W'(1);
    end
  end

  // Next-state and registered-output logic; priority alarm > manual > scan.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    alarm_d = 1'b0;
    err_d   = 1'b0;
    mask_d  = '0;

    if (|bus.alarm_in) begin
      state_d = ST_ALARM;
      idx_d   = alarm_idx;
      cnt_d   = '0;
      alarm_d = 1'b1;
    end else if (bus.mode) begin
      state_d = ST_MANUAL;
      cnt_d   = '0;
      if (bus.sel_valid) begin
        if (sel_in_range) idx_d = bus.manual_sel;
        else              err_d = 1'b1;
      end
    end else begin
      state_d = ST_SCAN;
      // The edge that re-enters SCAN only restarts the dwell, so the first
      // camera after ALARM/MANUAL gets a full dwell period.
      if (state_q != ST_SCAN) begin
        cnt_d = '0;
      end else if (bus.enable) begin
        if (expire) begin
          idx_d = adv_idx;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
    end

    step_d = (idx_d != idx_q);
    for (int c = 0; c < int'(NUM_CAMS); c++) begin
      mask_d[c*BITS_PER_CAM +: BITS_PER_CAM] = {BITS_PER_CAM{idx_d == CAM_IDX_W'(c)}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SCAN;
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= MASK_W'({BITS_PER_CAM{1'b1}});
      step_q  <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      step_q  <= step_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
    end
  end

  assign bus.mask         = mask_q;
  assign bus.active_idx   = idx_q;
  assign bus.step         = step_q;
  assign bus.alarm_active = alarm_q;
  assign bus.sel_err      = err_q;

endmodule

// File: tb/tb_camera_scan_sequencer.sv
// Self-checking bench for camera_scan_sequencer: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_camera_scan_sequencer;
  localparam int unsigned N  = 3;
  localparam int unsigned B  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned MW = N * B;
  localparam int unsigned VW = MW + IW + 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  camera_scan_sequencer_if #(.NUM_CAMS(N), .BITS_PER_CAM(B), .DWELL_W(DW)) bus ();

  camera_scan_sequencer #(.NUM_CAMS(N), .BITS_PER_CAM(B), .DWELL_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: mode 0 = scanning, 1 = manual, 2 = alarm; m_cnt counts elapsed dwell cycles.
  int m_idx = 0, m_cnt = 0, m_mode = 0;
  bit m_step = 0, m_alarm = 0, m_err = 0;

  function automatic logic [MW-1:0] grp_mask(int idx);
    return MW'(((1 << B) - 1) << (idx * B));
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {grp_mask(m_idx), IW'(m_idx), m_step, m_alarm, m_err};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.mask, bus.active_idx, bus.step, bus.alarm_active, bus.sel_err};
  endfunction

  // Advance the model with the current inputs, then one clock edge.
  task automatic cycle();
    int ni, nm, eff;
    if (reset) begin
      m_idx = 0; m_cnt = 0; m_mode = 0; m_step = 0; m_alarm = 0; m_err = 0;
    end else begin
      ni = m_idx;
      m_err = 0;
      if (bus.alarm_in != '0) begin
        nm = 2;
        m_cnt = 0;
        for (int i = N - 1; i >= 0; i--) if (bus.alarm_in[i]) ni = i;
      end else if (bus.mode) begin
        nm = 1;
        m_cnt = 0;
        if (bus.sel_valid) begin
          if (int'(bus.manual_sel) < N) ni = int'(bus.manual_sel);
          else m_err = 1;
        end
      end else begin
        nm = 0;
        eff = (bus.dwell == 0) ? 1 : int'(bus.dwell);
        if (m_mode != 0) m_cnt = 0;
        else if (bus.enable) begin
          m_cnt++;
          if (m_cnt >= eff) begin
            m_cnt = 0;
            ni = bus.dir ? (ni + N - 1) % N : (ni + 1) % N;
          end
        end
      end
      m_step  = (ni != m_idx);
      m_alarm = (nm == 2);
      m_idx   = ni;
      m_mode  = nm;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    tests++;
    if (obs_vec() !== {9'd7, 2'd0, 3'b000}) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), {9'd7, 2'd0, 3'b000});
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [MW-1:0] seq [4];
    int nsteps;
    seq[0] = 9'd56; seq[1] = 9'd448; seq[2] = 9'd7; seq[3] = 9'd56;
    bus.enable = 1'b1; bus.dwell = 8'd1; bus.dir = 1'b0; bus.mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests++;
      if (bus.mask !== seq[k] || bus.step !== 1'b1 || obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL scan_up[%0d]: got mask %0d step %b, expected mask %0d step 1", k, bus.mask, bus.step, seq[k]);
      end
    end
    bus.dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests++;
      if (obs_vec() !== exp_vec() || bus.step !== 1'b1) begin
        fails++;
        $display("FAIL scan_down[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    bus.dwell = 8'd4;
    nsteps = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      nsteps += int'(bus.step);
      tests++;
      if (obs_vec() !== exp_vec() || bus.step !== ((k % 4) == 3)) begin
        fails++;
        $display("FAIL dwell4[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (nsteps != 3) begin
      fails++;
      $display("FAIL dwell4_steps: got %0d expected 3", nsteps);
    end
    bus.dwell = 8'd0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests++;
      if (obs_vec() !== exp_vec() || bus.step !== 1'b1) begin
        fails++;
        $display("FAIL dwell0[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_alarm();
    reset = 1'b1; cycle(); reset = 1'b0;
    bus.enable = 1'b1; bus.dwell = 8'd1; bus.dir = 1'b0;
    cycle();
    bus.dwell = 8'd4;
    bus.alarm_in = 3'b110;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests++;
      if (bus.mask !== 9'd56 || bus.alarm_active !== 1'b1 || obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL alarm_hold[%0d]: got mask %0d alarm %b expected mask 56 alarm 1", k, bus.mask, bus.alarm_active);
      end
    end
    bus.alarm_in = 3'b100;
    cycle();
    tests++;
    if (bus.mask !== 9'd448 || bus.step !== 1'b1 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL alarm_track: got mask %0d step %b expected mask 448 step 1", bus.mask, bus.step);
    end
    bus.alarm_in = 3'b000;
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests++;
      if (bus.alarm_active !== 1'b0 || bus.mask !== ((k < 4) ? 9'd448 : 9'd7) || obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL alarm_exit[%0d]: got mask %0d alarm %b expected mask %0d alarm 0", k, bus.mask, bus.alarm_active, (k < 4) ? 448 : 7);
      end
    end
  endtask

  task automatic test_manual();
    bus.mode = 1'b1; bus.sel_valid = 1'b1; bus.manual_sel = 2'd2;
    cycle();
    tests++;
    if (bus.mask !== 9'd448 || bus.step !== 1'b1 || bus.sel_err !== 1'b0 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL manual_sel2: got %h expected %h", obs_vec(), exp_vec());
    end
    bus.manual_sel = 2'd3;
    cycle();
    tests++;
    if (bus.mask !== 9'd448 || bus.sel_err !== 1'b1 || bus.step !== 1'b0 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL manual_oor: got %h expected %h", obs_vec(), exp_vec());
    end
    bus.sel_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.enable = k[0];
      cycle();
      tests++;
      if (bus.mask !== 9'd448 || bus.sel_err !== 1'b0 || bus.step !== 1'b0 || obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL manual_hold[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    bus.mode = 1'b0; bus.enable = 1'b1;
  endtask

  task automatic test_hold();
    reset = 1'b1; cycle(); reset = 1'b0;
    bus.dir = 1'b0; bus.dwell = 8'd6; bus.enable = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      tests++;
      if (bus.mask !== 9'd7 || bus.step !== 1'b0 || obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL hold_frozen[%0d]: got mask %0d step %b expected mask 7 step 0", k, bus.mask, bus.step);
      end
    end
    bus.enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests++;
      if (bus.mask !== ((k < 2) ? 9'd7 : 9'd56) || obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL hold_resume[%0d]: got mask %0d expected %0d", k, bus.mask, (k < 2) ? 7 : 56);
      end
    end
  endtask

  task automatic test_reset_mid_alarm();
    bus.alarm_in = 3'b100; bus.mode = 1'b1; bus.sel_valid = 1'b1; bus.manual_sel = 2'd3;
    cycle();
    reset = 1'b1;
    cycle();
    tests++;
    if (obs_vec() !== {9'd7, 2'd0, 3'b000} || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_mid_alarm: got %h expected %h", obs_vec(), {9'd7, 2'd0, 3'b000});
    end
    reset = 1'b0; bus.alarm_in = '0; bus.mode = 1'b0; bus.sel_valid = 1'b0;
    cycle();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL post_reset_scan: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset         = ($urandom_range(0, 59) == 0);
      bus.enable    = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) bus.dir = ~bus.dir;
      if ($urandom_range(0, 19) == 0) bus.dwell = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 11) == 0) bus.mode = ~bus.mode;
      bus.sel_valid  = ($urandom_range(0, 2) == 0);
      bus.manual_sel = IW'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        bus.alarm_in = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom_range(1, 7));
      cycle();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.dir = 1'b0; bus.dwell = 8'd1; bus.mode = 1'b0;
    bus.manual_sel = '0; bus.sel_valid = 1'b0; bus.alarm_in = '0;
    test_reset();
    test_scan();
    test_alarm();
    test_manual();
    test_hold();
    test_reset_mid_alarm();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/camera_scan_sequencer.md
Name: camera_scan_sequencer

Overview:
Parametrised surveillance camera sequencer. It drives a one-group-hot activation mask over NUM_CAMS cameras, each camera owning BITS_PER_CAM adjacent mask bits. The block supports timed auto-scan in either direction, manual camera selection and alarm override. It sits between the control panel inputs and the camera/monitor enable lines.

Parameters:
NUM_CAMS, 3, number of cameras (>= 2)
BITS_PER_CAM, 3, mask bits per camera (>= 1)
DWELL_W, 8, width of the dwell-time input
CAM_IDX_W, $clog2(NUM_CAMS), localparam, camera index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  auto-scan run (1) / hold (0)
dir  in  1  scan direction: 0 ascending, 1 descending
dwell  in  DWELL_W  cycles each camera is held in auto-scan; 0 is treated as 1
mode  in  1  0 auto-scan, 1 manual
manual_sel  in  CAM_IDX_W  requested camera in manual mode
sel_valid  in  1  manual_sel strobe
alarm_in  in  NUM_CAMS  per-camera alarm level
mask  out  NUM_CAMS*BITS_PER_CAM  registered activation mask
active_idx  out  CAM_IDX_W  registered index of the active camera
step  out  1  one-cycle pulse, coincident with any change of active_idx
alarm_active  out  1  high while in ALARM state
sel_err  out  1  one-cycle pulse on an out-of-range manual request

Behaviour:
- Reset (clk edge with reset=1) overrides all other inputs, including mid-operation:
  - active_idx=0; mask=2**BITS_PER_CAM-1 (7 at defaults); dwell_cnt=0; state=SCAN.
  - step=0, alarm_active=0, sel_err=0.
- Mask encoding:
  - mask = {BITS_PER_CAM{1'b1}} << (active_idx*BITS_PER_CAM).
  - Registered on the same edge as active_idx, so the two are always consistent.
  - Exactly one group is set at all times.
- States: SCAN, MANUAL, ALARM. Next state is evaluated every edge with priority alarm > mode > scan:
  - any alarm_in bit high -> ALARM
  - else mode=1 -> MANUAL
  - else SCAN
- SCAN:
  - enable=0: active_idx and dwell_cnt hold.
  - enable=1: dwell_cnt increments each cycle.
  - When dwell_cnt >= dwell_eff-1 (dwell_eff = max(dwell,1)): the camera advances, dwell_cnt<=0, step=1.
  - The >= compare covers dwell lowered during operation.
  - Advance with dir=0: idx+1, wrapping NUM_CAMS-1 -> 0.
  - Advance with dir=1: idx-1, wrapping 0 -> NUM_CAMS-1.
  - dir and dwell are sampled live each cycle.
- MANUAL:
  - No auto-advance; dwell_cnt held at 0.
  - sel_valid with manual_sel < NUM_CAMS: active_idx<=manual_sel next edge. step=1 only if the index changes.
  - sel_valid with manual_sel >= NUM_CAMS: index unchanged, sel_err=1 for one cycle.
  - sel_valid outside MANUAL is ignored (no sel_err).
- ALARM:
  - Each edge, active_idx <= lowest-numbered set bit of alarm_in; alarm_active=1; dwell_cnt=0.
  - Tracks changes in alarm_in every cycle.
  - Latency: alarm_in asserted before edge N -> mask/alarm_active updated at edge N.
- Leaving ALARM or MANUAL:
  - The next state starts from the current active_idx with dwell_cnt=0.
  - On return to SCAN, the first advance occurs after a full dwell_eff cycles.
- Simultaneous events:
  - alarm beats sel_valid; the manual request is dropped and no sel_err is raised.
  - A mode change and a dwell expiry in the same cycle: the mode change wins, with no advance.
- step, sel_err: registered pulses, exactly one cycle wide.

Test Plan:
- Reset, mode=0, enable=1, dwell=1, dir=0 -> mask 7,56,448,7,... one per cycle; step high every cycle.
- Same with dir=1 -> mask 7,448,56,7; dwell=4 -> each value held exactly 4 cycles, step once per 4 cycles; dwell=0 behaves as 1.
- Scanning at idx 1 (mask 56), alarm_in=3'b110 -> next edge mask 56, alarm_active=1 and held. Then alarm_in=3'b100 -> mask 448. Then alarm_in=0 -> alarm_active=0 and scan resumes, first advance after dwell_eff cycles (448 -> 7 with dir=0).
- mode=1, sel_valid with manual_sel=2 -> mask 448, step=1. manual_sel=3 -> sel_err pulse, mask stays 448. enable toggling has no effect.
- enable=0 mid-dwell for 10 cycles -> mask frozen; re-enable -> the remaining dwell count completes before advancing.
- reset asserted mid-ALARM with sel_valid active -> next edge mask=7, active_idx=0, all pulses 0, state SCAN.
